seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - APB-programmed 8-digit multiplexed seven-segment scan controller
module seg7_scan_ctrl #(
  parameter int DIV_RESET    = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [6:0]  seg_o,
  output logic [7:0]  an_o
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  localparam logic [19:0] DIV_INIT   = 20'(DIV_RESET);
  localparam logic [19:0] BLANK_INIT = 20'(BLANK_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_data, r_shadow, w_shadow_nxt;
  logic        r_en;
  logic [7:0]  r_digit_en;
  logic [19:0] r_div;
  logic [2:0]  r_digit, w_digit_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic [7:0]  r_an, w_an_nxt;
  logic [3:0]  w_nibble;
  logic        w_addr_err, w_wr;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_unused   = &{1'b0, paddr[1:0]};
  assign w_addr_err = |paddr[11:4];
  assign w_wr       = psel & penable & pwrite & ~w_addr_err;
  assign w_nibble   = r_shadow[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_rdata = 32'h0;
    case (paddr[3:2])
      2'd0:    w_rdata = r_data;
      2'd1:    w_rdata = {16'h0, r_digit_en, 7'h0, r_en};
      2'd2:    w_rdata = {12'h0, r_div};
      default: w_rdata = {28'h0, (r_state != S_IDLE), r_digit};
    endcase
  end

  assign prdata  = (psel && !w_addr_err) ? w_rdata : 32'h0;
  assign pslverr = psel & penable & w_addr_err;
  assign pready  = 1'b1;

  // Outputs are computed for the state being entered so they change on the transition edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_digit_nxt  = r_digit;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_an_nxt     = 8'hFF;
    w_seg_nxt    = 7'h7F;
    if (!r_en) begin
      w_state_nxt = S_IDLE;
      w_digit_nxt = 3'd0;
      w_cnt_nxt   = 20'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_BLANK;
          w_digit_nxt  = 3'd0;
          w_cnt_nxt    = BLANK_INIT;
          w_shadow_nxt = r_data;
        end
        S_BLANK: begin
          if (r_cnt == 20'd0) begin
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = r_div - 20'd1;
          end else begin
            w_cnt_nxt = r_cnt - 20'd1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == 20'd0) begin
            w_state_nxt = S_BLANK;
            w_digit_nxt = r_digit + 3'd1;
            w_cnt_nxt   = BLANK_INIT;
            if (r_digit == 3'd7) w_shadow_nxt = r_data;
          end else begin
            w_cnt_nxt = r_cnt - 20'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_state_nxt == S_DRIVE) begin
      w_seg_nxt = hex7(w_nibble);
      if (r_digit_en[r_digit]) w_an_nxt = ~(8'h01 << r_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_digit    <= 3'd0;
      r_cnt      <= 20'd0;
      r_shadow   <= 32'h0;
      r_data     <= 32'h0;
      r_en       <= 1'b0;
      r_digit_en <= 8'hFF;
      r_div      <= DIV_INIT;
      r_an       <= 8'hFF;
      r_seg      <= 7'h7F;
    end else begin
      r_state  <= w_state_nxt;
      r_digit  <= w_digit_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
      if (w_wr) begin
        case (paddr[3:2])
          2'd0: r_data <= pwdata;
          2'd1: begin
            r_en       <= pwdata[0];
            r_digit_en <= pwdata[15:8];
          end
          2'd2: r_div <= (pwdata[19:0] == 20'd0) ? 20'd1 : pwdata[19:0];
          default: ;
        endcase
      end
    end
  end

  assign seg_o = r_seg;
  assign an_o  = r_an;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [6:0]  seg_o;
  logic [7:0]  an_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16];
  logic [7:0] q_an[$];
  logic [7:0] q_seg[$];

  seg7_scan_ctrl #(.DIV_RESET(5), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_now(input logic [11:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    d = prdata; e = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One frame: per digit, BC blank clocks then div drive clocks; 8'hFF in q_seg = unchecked.
  task automatic build_frame(input logic [31:0] data, input logic [7:0] den, input int div);
    for (int d = 0; d < 8; d++) begin
      for (int b = 0; b < BC; b++) begin
        q_an.push_back(8'hFF); q_seg.push_back(8'h7F);
      end
      for (int c = 0; c < div; c++) begin
        q_an.push_back(den[d] ? ~(8'h01 << d) : 8'hFF);
        q_seg.push_back(den[d] ? {1'b0, seg_tab[data[d*4 +: 4]]} : 8'hFF);
      end
    end
  endtask

  task automatic run_trace(input int wr_at, input logic [11:0] wa, input logic [31:0] wd);
    int i = 0;
    logic [7:0] ea, es;
    while (q_an.size() > 0) begin
      @(posedge clk); #1;
      ea = q_an.pop_front(); es = q_seg.pop_front();
      chk($sformatf("an_o[%0d]", i), {24'h0, an_o}, {24'h0, ea});
      if (es != 8'hFF) chk($sformatf("seg_o[%0d]", i), {25'h0, seg_o}, {24'h0, es});
      if (i == wr_at) begin
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = wa; pwdata = wd;
      end else if (i == wr_at + 1) begin
        penable = 1'b1;
      end else if (i == wr_at + 2) begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      end
      i++;
    end
  endtask

  task automatic stop_and_check(input string tag);
    logic [31:0] d; logic e;
    apb_write(12'h004, 32'h0000FF00);
    @(posedge clk); #1;
    rd_now(12'h00C, d, e);
    chk({tag, "_an"}, {24'h0, an_o}, 32'hFF);
    chk({tag, "_busy"}, {31'h0, d[3]}, 32'h0);
  endtask

  initial begin
    logic [31:0] d, rdata;
    logic        e;
    logic [7:0]  den;
    int          div;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_an", {24'h0, an_o}, 32'hFF);
    chk("rst_seg", {25'h0, seg_o}, 32'h7F);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    chk("prdata_idle", prdata, 32'h0);
    rd_now(12'h00C, rdata, e); chk("rst_status", rdata, 32'h0);
    rd_now(12'h004, rdata, e); chk("rst_ctrl", rdata, 32'h0000FF00);
    rd_now(12'h008, rdata, e); chk("rst_div", rdata, 32'd5);
    rd_now(12'h000, rdata, e); chk("rst_data", rdata, 32'h0);

    rd_now(12'h010, rdata, e);
    chk("bad_err", {31'h0, e}, 32'h1);
    chk("bad_prdata", rdata, 32'h0);
    apb_write(12'h010, 32'hDEADBEEF);
    apb_write(12'h018, 32'h7);
    rd_now(12'h000, rdata, e); chk("bad_wr_data", rdata, 32'h0);
    rd_now(12'h008, rdata, e); chk("bad_wr_div", rdata, 32'd5);
    chk("good_err", {31'h0, e}, 32'h0);
    apb_write(12'h008, 32'h0);
    rd_now(12'h008, rdata, e); chk("div_zero", rdata, 32'd1);

    apb_write(12'h008, 32'd3);
    apb_write(12'h000, 32'h76543210);
    apb_write(12'h004, 32'h0000FF01);
    build_frame(32'h76543210, 8'hFF, 3);
    build_frame(32'h76543210, 8'hFF, 3);
    run_trace(-1, 12'h0, 32'h0);
    stop_and_check("stop1");

    apb_write(12'h000, 32'h13579BDF);
    apb_write(12'h004, 32'h0000FF01);
    build_frame(32'h13579BDF, 8'hFF, 3);
    build_frame(32'h88888888, 8'hFF, 3);
    run_trace(3 * (BC + 3) + BC, 12'h000, 32'h88888888);
    stop_and_check("stop2");

    apb_write(12'h008, 32'd2);
    apb_write(12'h000, 32'hFFFFFFFF);
    apb_write(12'h004, 32'h00000501);
    build_frame(32'hFFFFFFFF, 8'h05, 2);
    run_trace(-1, 12'h0, 32'h0);
    stop_and_check("stop3");

    for (int k = 0; k < 4; k++) begin
      d   = $urandom;
      den = 8'($urandom_range(0, 255));
      div = $urandom_range(1, 4);
      apb_write(12'h008, 32'(div));
      apb_write(12'h000, d);
      apb_write(12'h004, {16'h0, den, 8'h01});
      build_frame(d, den, div);
      run_trace(-1, 12'h0, 32'h0);
      stop_and_check($sformatf("rnd%0d", k));
    end

    apb_write(12'h008, 32'd20);
    apb_write(12'h000, 32'h00000009);
    apb_write(12'h004, 32'h0000FF01);
    repeat (5) @(posedge clk);
    #1;
    chk("drv_an", {24'h0, an_o}, 32'hFE);
    chk("drv_seg", {25'h0, seg_o}, 32'h10);
    stop_and_check("en_clear_drive");

    apb_write(12'h004, 32'h0000FF01);
    repeat (5) @(posedge clk);
    #1;
    chk("drv2_an", {24'h0, an_o}, 32'hFE);
    rst_n = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hAAAA5555;
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("rst_mid_an", {24'h0, an_o}, 32'hFF);
    chk("rst_mid_seg", {25'h0, seg_o}, 32'h7F);
    rd_now(12'h00C, rdata, e); chk("rst_mid_busy", {31'h0, rdata[3]}, 32'h0);
    rd_now(12'h000, rdata, e); chk("rst_mid_data", rdata, 32'h0);
    rd_now(12'h008, rdata, e); chk("rst_mid_div", rdata, 32'd5);

    apb_write(12'h008, 32'd1);
    apb_write(12'h000, 32'h0000000A);
    apb_write(12'h004, 32'h0000FF01);
    build_frame(32'h0000000A, 8'hFF, 1);
    run_trace(-1, 12'h0, 32'h0);
    stop_and_check("stop_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
